// File: rtl/tcp_tx_arbiter.sv
// Packet-atomic round-robin arbiter feeding the SiTCP TX FIFO write port.
// Define TX_ARB_HEADER_EN to prefix each packet with {4'hA,1'b0,id[2:0]}.
module tcp_tx_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic               CLK_200M,
  input  logic               SYS_RSTn,
  input  logic [N_REQ-1:0]   REQ_VALID,
  input  logic [8*N_REQ-1:0] REQ_DATA,
  input  logic [N_REQ-1:0]   REQ_LAST,
  output logic [N_REQ-1:0]   REQ_READY,
  input  logic               FIFO_FULL,
  input  logic               TCP_OPEN_ACK,
  output logic [7:0]         TCP_TX_DATA_IN,
  output logic               TCP_TX_EN_IN,
  output logic [N_REQ-1:0]   GRANT,
  output logic [15:0]        PKT_CNT,
  output logic [15:0]        DROP_CNT
);

`ifdef TX_ARB_HEADER_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_HDR = 2'd1, S_XFER = 2'd2, S_FLUSH = 2'd3} state_e;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_XFER = 2'd2, S_FLUSH = 2'd3} state_e;
`endif

  state_e             state_q, state_d;
  logic [2:0]         ptr_q, ptr_d;
  logic [2:0]         gidx_q, gidx_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic               en_q, en_d;
  logic [7:0]         data_q, data_d;
  logic [15:0]        pkt_cnt_q, pkt_cnt_d;
  logic [15:0]        drop_cnt_q, drop_cnt_d;

  logic               sel_vld, sel_last;
  logic [7:0]         sel_data;
  logic               win_found;
  logic [2:0]         win_idx;
  logic [3:0]         scan_j;

  // Mux the owner's lane
  always_comb begin
    sel_vld  = 1'b0;
    sel_last = 1'b0;
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gidx_q == 3'(i)) begin
        sel_vld  = REQ_VALID[i];
        sel_last = REQ_LAST[i];
        sel_data = REQ_DATA[8*i +: 8];
      end
    end
  end

  // First valid requester at or after the pointer, wrapping modulo N_REQ
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_j    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_j = {1'b0, ptr_q} + 4'(k);
      if (scan_j >= 4'(N_REQ)) scan_j = scan_j - 4'(N_REQ);
      for (int i = 0; i < N_REQ; i++) begin
        if (!win_found && scan_j == 4'(i) && REQ_VALID[i]) begin
          win_found = 1'b1;
          win_idx   = 3'(i);
        end
      end
    end
  end

  // READY is combinational so a rising FIFO_FULL blocks the same-cycle byte
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      REQ_READY[i] = (gidx_q == 3'(i)) &&
                     ((state_q == S_XFER && !FIFO_FULL && TCP_OPEN_ACK) ||
                      state_q == S_FLUSH);
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gidx_d     = gidx_q;
    grant_d    = grant_q;
    en_d       = 1'b0;
    data_d     = data_q;
    pkt_cnt_d  = pkt_cnt_q;
    drop_cnt_d = drop_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (TCP_OPEN_ACK && win_found) begin
          gidx_d = win_idx;
          ptr_d  = (win_idx == 3'(N_REQ-1)) ? 3'd0 : win_idx + 3'd1;
          for (int i = 0; i < N_REQ; i++) grant_d[i] = (win_idx == 3'(i));
`ifdef TX_ARB_HEADER_EN
          state_d = S_HDR;
`else
          state_d = S_XFER;
`endif
        end
      end
`ifdef TX_ARB_HEADER_EN
      S_HDR: begin
        if (!TCP_OPEN_ACK) begin
          state_d = S_FLUSH;
        end else if (!FIFO_FULL) begin
          en_d    = 1'b1;
          data_d  = {4'hA, 1'b0, gidx_q};
          state_d = S_XFER;
        end
      end
`endif
      S_XFER: begin
        if (!TCP_OPEN_ACK) begin
          state_d = S_FLUSH;
        end else if (sel_vld && !FIFO_FULL) begin
          en_d   = 1'b1;
          data_d = sel_data;
          if (sel_last) begin
            pkt_cnt_d = pkt_cnt_q + 16'd1;
            grant_d   = '0;
            state_d   = S_IDLE;
          end
        end
      end
      S_FLUSH: begin
        // The FIFO is cleared on connection loss, so the rest is discarded
        if (sel_vld && sel_last) begin
          drop_cnt_d = drop_cnt_q + 16'd1;
          grant_d    = '0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_200M or negedge SYS_RSTn) begin
    if (!SYS_RSTn) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      gidx_q     <= '0;
      grant_q    <= '0;
      en_q       <= 1'b0;
      data_q     <= '0;
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gidx_q     <= gidx_d;
      grant_q    <= grant_d;
      en_q       <= en_d;
      data_q     <= data_d;
      pkt_cnt_q  <= pkt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign TCP_TX_EN_IN   = en_q;
  assign TCP_TX_DATA_IN = data_q;
  assign GRANT          = grant_q;
  assign PKT_CNT        = pkt_cnt_q;
  assign DROP_CNT       = drop_cnt_q;

endmodule

// File: tb/tb_tcp_tx_arbiter.sv
// Scoreboard bench for tcp_tx_arbiter: queued requester models, expected
// byte/grant queues checked by an independent output monitor.
module tb_tcp_tx_arbiter;
  localparam int N = 4;
`ifdef TX_ARB_HEADER_EN
  localparam int HL = 1;
`else
  localparam int HL = 0;
`endif

  logic           clk = 1'b0;
  logic           SYS_RSTn;
  logic [N-1:0]   REQ_VALID, REQ_LAST, REQ_READY, GRANT;
  logic [8*N-1:0] REQ_DATA;
  logic           FIFO_FULL, TCP_OPEN_ACK, TCP_TX_EN_IN;
  logic [7:0]     TCP_TX_DATA_IN;
  logic [15:0]    PKT_CNT, DROP_CNT;

  always #5 clk = ~clk;

  tcp_tx_arbiter #(.N_REQ(N)) dut (
    .CLK_200M(clk), .SYS_RSTn(SYS_RSTn),
    .REQ_VALID(REQ_VALID), .REQ_DATA(REQ_DATA), .REQ_LAST(REQ_LAST),
    .REQ_READY(REQ_READY), .FIFO_FULL(FIFO_FULL), .TCP_OPEN_ACK(TCP_OPEN_ACK),
    .TCP_TX_DATA_IN(TCP_TX_DATA_IN), .TCP_TX_EN_IN(TCP_TX_EN_IN),
    .GRANT(GRANT), .PKT_CNT(PKT_CNT), .DROP_CNT(DROP_CNT)
  );

  logic [8:0] txq [N][$];
  logic [7:0] exp_q [$];
  int         gnt_exp [$];
  int         en_cyc [$];
  int         n_vec = 0, n_err = 0;
  int         acc_total = 0, cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send(input int id, input int base, input int step, input int len, input int nexp);
    for (int k = 0; k < len; k++)
      txq[id].push_back({(k == len-1), 8'(base + k*step)});
    gnt_exp.push_back(id);
`ifdef TX_ARB_HEADER_EN
    exp_q.push_back(8'hA0 | 8'(id));
`endif
    for (int k = 0; k < nexp; k++) exp_q.push_back(8'(base + k*step));
  endtask

  function automatic bit busy();
    busy = (exp_q.size() != 0) || (GRANT != 0) || TCP_TX_EN_IN;
    for (int i = 0; i < N; i++) if (txq[i].size() != 0) busy = 1'b1;
  endfunction

  task automatic wait_drain(input string nm);
    int b;
    b = 0;
    while (busy() && b < 500) begin @(negedge clk); b++; end
    if (busy()) begin
      n_vec++; n_err++;
      $display("FAIL %s: drain timeout, %0d bytes still expected", nm, exp_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_acc(input int tgt);
    int b;
    b = 0;
    while (acc_total < tgt && b < 200) begin @(negedge clk); b++; end
    if (acc_total < tgt) chk("wait_acc_timeout", 32'(acc_total), 32'(tgt));
  endtask

  // Requester models: present queue heads, pop on handshake
  initial begin : driver
    logic [N-1:0] acc;
    REQ_VALID = '0; REQ_LAST = '0; REQ_DATA = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (txq[i].size() > 0) begin
          REQ_VALID[i] = 1'b1;
          REQ_DATA[8*i +: 8] = txq[i][0][7:0];
          REQ_LAST[i] = txq[i][0][8];
        end else begin
          REQ_VALID[i] = 1'b0;
          REQ_LAST[i] = 1'b0;
        end
      end
      #4;
      acc = REQ_VALID & REQ_READY;
      @(posedge clk);
      for (int i = 0; i < N; i++)
        if (acc[i] && txq[i].size() > 0) begin
          void'(txq[i].pop_front());
          acc_total++;
        end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin : monitor
    logic [N-1:0] prev_gnt;
    prev_gnt = '0;
    forever begin
      @(negedge clk);
      if (SYS_RSTn) begin
        if (TCP_TX_EN_IN) begin
          if (exp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL tx_unexpected: got byte %0h, none expected", TCP_TX_DATA_IN);
          end else chk("tx_byte", 32'(TCP_TX_DATA_IN), 32'(exp_q.pop_front()));
          en_cyc.push_back(cyc);
        end
        if (GRANT != 0 && prev_gnt == 0) begin
          if (gnt_exp.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL grant_unexpected: got %0h, none expected", GRANT);
          end else chk("grant", 32'(GRANT), 32'(1) << gnt_exp.pop_front());
        end
      end
      prev_gnt = GRANT;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "timeout");
  end

  initial begin : main
    int base, bad;
    SYS_RSTn = 1'b0; FIFO_FULL = 1'b0; TCP_OPEN_ACK = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_grant", 32'(GRANT), 0);
    chk("rst_en", 32'(TCP_TX_EN_IN), 0);
    chk("rst_data", 32'(TCP_TX_DATA_IN), 0);
    chk("rst_pkt", 32'(PKT_CNT), 0);
    chk("rst_drop", 32'(DROP_CNT), 0);
    SYS_RSTn = 1'b1;
    @(negedge clk);

    // Round robin, 2-byte packets, all four continuously valid
    en_cyc.delete();
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < N; i++) send(i, i*16 + p*2, 1, 2, 2);
    wait_drain("rr");
    chk("rr_pkt_cnt", 32'(PKT_CNT), 8);
    chk("rr_nbytes", 32'(en_cyc.size()), 32'(8*(2+HL)));
    bad = 0;
    for (int j = 1; j < en_cyc.size(); j++)
      if (en_cyc[j] - en_cyc[j-1] != ((j % (2+HL) == 0) ? 2 : 1)) bad++;
    chk("rr_spacing", 32'(bad), 0);

    // Single requester, consecutive bytes
    en_cyc.delete();
    send(1, 8'h11, 8'h11, 3, 3);
    wait_drain("single");
    chk("single_pkt_cnt", 32'(PKT_CNT), 9);
    chk("single_grant_clear", 32'(GRANT), 0);
    chk("single_nbytes", 32'(en_cyc.size()), 32'(3+HL));
    bad = 0;
    for (int j = 1; j < en_cyc.size(); j++) if (en_cyc[j] - en_cyc[j-1] != 1) bad++;
    chk("single_spacing", 32'(bad), 0);

    // Backpressure mid-packet
    base = acc_total;
    send(3, 8'hB0, 1, 4, 4);
    wait_acc(base + 2);
    #1 chk("bp_ready_pre", 32'(REQ_READY), 32'h8);
    FIFO_FULL = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1 chk("bp_ready_full", 32'(REQ_READY), 0);
      @(negedge clk);
    end
    FIFO_FULL = 1'b0;
    #1 chk("bp_ready_post", 32'(REQ_READY), 32'h8);
    chk("bp_acc_held", 32'(acc_total), 32'(base + 2));
    wait_drain("bp");
    chk("bp_pkt_cnt", 32'(PKT_CNT), 10);

    // Connection drop after byte 2 of 6
    base = acc_total;
    send(2, 8'hC0, 1, 6, 2);
    wait_acc(base + 2);
    TCP_OPEN_ACK = 1'b0;
    txq[0].push_back({1'b1, 8'hD0});
    wait_acc(base + 6);
    repeat (5) @(negedge clk);
    chk("drop_cnt", 32'(DROP_CNT), 1);
    chk("drop_grant_hold", 32'(GRANT), 0);
    chk("drop_pkt_cnt", 32'(PKT_CNT), 10);
    chk("drop_no_grant", 32'(txq[0].size()), 1);
    gnt_exp.push_back(0);
`ifdef TX_ARB_HEADER_EN
    exp_q.push_back(8'hA0);
`endif
    exp_q.push_back(8'hD0);
    TCP_OPEN_ACK = 1'b1;
    wait_drain("reopen");
    chk("reopen_pkt_cnt", 32'(PKT_CNT), 11);

    // Asynchronous reset mid-packet; pointer would otherwise favour 3
    base = acc_total;
    send(2, 8'hE0, 1, 4, 2);
    wait_acc(base + 2);
    #2 SYS_RSTn = 1'b0;
    #1;
    chk("arst_grant", 32'(GRANT), 0);
    chk("arst_ready", 32'(REQ_READY), 0);
    chk("arst_en", 32'(TCP_TX_EN_IN), 0);
    chk("arst_data", 32'(TCP_TX_DATA_IN), 0);
    chk("arst_pkt", 32'(PKT_CNT), 0);
    chk("arst_drop", 32'(DROP_CNT), 0);
    chk("arst_bytes_out", 32'(exp_q.size()), 0);
    for (int i = 0; i < N; i++) txq[i].delete();
    exp_q.delete();
    gnt_exp.delete();
    repeat (2) @(negedge clk);
    SYS_RSTn = 1'b1;
    send(1, 8'hF1, 1, 1, 1);
    send(3, 8'hF3, 1, 1, 1);
    wait_drain("post_rst");
    chk("post_rst_pkt", 32'(PKT_CNT), 2);

    // Counter wrap
    force dut.pkt_cnt_q = 16'hFFFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    release dut.pkt_cnt_q;
    #1 chk("wrap_pre", 32'(PKT_CNT), 32'hFFFF);
    send(0, 8'h5A, 1, 1, 1);
    wait_drain("wrap");
    chk("wrap_pkt_cnt", 32'(PKT_CNT), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/tcp_tx_arbiter.md
# tcp_tx_arbiter

Packet-atomic round-robin arbiter that shares the single SiTCP transmit byte stream among up to 8 data producers, such as TDC readout channels. It sits between the producers and the SiTCP wrapper's TX FIFO write port (TCP_TX_DATA_IN / TCP_TX_EN_IN). It honours the FIFO programmable-full flag and the TCP connection state. Once a producer is granted, its whole packet is forwarded before any other producer can be granted.

## Interface
- N_REQ, 4, number of requesters, legal range 2..8
- CLK_200M  in  1  system clock; all logic is on its rising edge
- SYS_RSTn  in  1  asynchronous, active-low reset
- REQ_VALID  in  N_REQ  per-requester byte valid
- REQ_DATA  in  8*N_REQ  per-requester byte; requester i drives bits [8i+7:8i]
- REQ_LAST  in  N_REQ  marks the last byte of a packet; qualified by REQ_VALID
- REQ_READY  out  N_REQ  per-requester accept; a byte transfers when VALID & READY
- FIFO_FULL  in  1  TX FIFO prog_full flag; the FIFO guarantees at least 4 bytes of headroom after assertion
- TCP_OPEN_ACK  in  1  connection established
- TCP_TX_DATA_IN  out  8  byte to the TX FIFO
- TCP_TX_EN_IN  out  1  write strobe to the TX FIFO
- GRANT  out  N_REQ  one-hot current owner; all zeros when no owner
- PKT_CNT  out  16  count of packets forwarded; wraps from 0xFFFF to 0
- DROP_CNT  out  16  count of packets discarded; wraps

## Operation
- Reset values:
  - all outputs are 0
  - round-robin pointer is 0
  - state is IDLE
- States: IDLE, HDR (present only when the header feature is compiled in), XFER, FLUSH.
- IDLE:
  - No grant is made while TCP_OPEN_ACK=0.
  - Otherwise, scan REQ_VALID starting at the pointer index and wrapping modulo N_REQ. The first set bit wins.
  - The winner's GRANT bit is set and the pointer becomes winner+1 (mod N_REQ).
  - Next state is HDR, or XFER if HDR is compiled out.
- HDR: emits one header byte when FIFO_FULL=0 and TCP_OPEN_ACK=1, then moves to XFER. REQ_READY stays 0 in this state.
- XFER:
  - REQ_READY[g] = FIFO_FULL=0 & TCP_OPEN_ACK=1. All other REQ_READY bits are 0.
  - Each accepted byte is forwarded to TCP_TX_DATA_IN.
  - Accepting a byte with LAST set: PKT_CNT is incremented, GRANT clears, next state is IDLE.
- FLUSH:
  - Entered from HDR or XFER when TCP_OPEN_ACK falls.
  - REQ_READY[g]=1 unconditionally. Bytes are consumed with TCP_TX_EN_IN=0.
  - Accepting a byte with LAST set: DROP_CNT is incremented, next state is IDLE.
  - A packet that is partially written when the connection drops is lost along with the FIFO contents, which the connection-loss reset clears.
- Simultaneous FIFO_FULL rising and a valid byte in the same cycle: the byte is not accepted (READY is combinational from FIFO_FULL).
- A requester must not drop REQ_VALID or change REQ_DATA/REQ_LAST while VALID=1 and READY=0. Behaviour is undefined if it does.
- A requester that goes idle mid-packet (VALID=0) holds the grant indefinitely. There is no timeout.

## Timing
- TCP_TX_EN_IN and TCP_TX_DATA_IN are registered: a byte accepted in cycle t appears at t+1.
- Grant latency: REQ_VALID seen in IDLE at cycle t gives GRANT at t+1.
  - First payload READY at t+1 without HDR, or t+2 with HDR.
- One idle cycle follows every LAST before the next grant. Peak throughput is L/(L+1) bytes per clock for an L-byte packet (L/(L+2) with HDR).
- FIFO_FULL to stop: zero cycles of READY. At most one registered byte is still in flight, which the FIFO headroom covers.
- Deasserting SYS_RSTn mid-packet aborts the packet immediately. No counter is updated.

## Configuration
- TX_ARB_HEADER_EN defined:
  - HDR state is present.
  - Each packet is prefixed with one byte {4'hA, 1'b0, id[2:0]}, where id is the granted index.
  - The header counts toward throughput but not toward PKT_CNT.
- TX_ARB_HEADER_EN undefined:
  - No HDR state; IDLE goes directly to XFER.
  - The stream is the concatenation of raw payloads.

## Test plan
- Single requester (N_REQ=4): req1 sends 3-byte packet 0x11,0x22,0x33 (LAST on 0x33), OPEN_ACK=1 -> TX EN pulses with 0x11,0x22,0x33 on consecutive cycles (preceded by 0xA1 with header); PKT_CNT=1; GRANT returns to 0.
- Round robin: all 4 requesters continuously valid with 2-byte packets -> grant order 0,1,2,3,0; no packet interleaving; exactly one idle cycle between packets.
- Backpressure: FIFO_FULL=1 for 5 cycles in the middle of a 4-byte packet -> REQ_READY=0 in exactly those cycles; no byte is lost or duplicated; output order is preserved.
- Connection drop: TCP_OPEN_ACK falls after byte 2 of a 6-byte packet -> remaining 4 bytes are consumed with EN=0; DROP_CNT=1; no grants until OPEN_ACK=1 again.
- Wrap and reset: preload 65535 packets (or force the counter) then send one more -> PKT_CNT=0. Assert SYS_RSTn=0 mid-packet -> all outputs 0 asynchronously; after release the first grant goes to the lowest valid index.
